// File: rtl/conv_weight_loader_if.sv
// Weight stream handshake between the host/DMA source and conv_weight_loader.
// The master drives s_data/s_valid; the loader (slave) answers with s_ready.
interface conv_weight_loader_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/conv_weight_loader.sv
// conv_weight_loader: writer side of the conv weight-write port.
// Takes a packed 32-bit word stream and sequences it into the conv address map:
// kernel words, bias words, one MACC coefficient, one layer scale. Each accepted
// word becomes one weight write on the following cycle. done pulses once all
// words are written, one cycle after the final write.
//
// Optional feature macro: WEIGHT_LOADER_CHECKSUM_EN
//   When defined, a trailer word follows the payload. It is compared with the
//   mod-2^32 sum of all payload words and is never written; a mismatch sets the
//   sticky err flag when done pulses. When undefined, there is no trailer and
//   err is tied low.
//
// State  | meaning
// IDLE   | waiting for start; also the cycle that carries the done pulse
// KERN   | accepting kernel words
// BIAS   | accepting bias words
// MACC   | accepting the MACC coefficient word
// SCALE  | accepting the layer-scale word
// CKSUM  | accepting the checksum trailer (checksum build only)
// DONE   | all words accepted; raises done for the following cycle
module conv_weight_loader #(
    parameter int KERNEL_0              = 3,
    parameter int KERNEL_1              = 3,
    parameter int IN_CHANNEL            = 2,
    parameter int OUT_CHANNEL           = 2,
    parameter int KERNEL_BASE_ADDR      = 0,
    parameter int BIAS_BASE_ADDR        = KERNEL_0 * KERNEL_1 * IN_CHANNEL * OUT_CHANNEL,
    parameter int MACC_COEFF_BASE_ADDR  = BIAS_BASE_ADDR + OUT_CHANNEL,
    parameter int LAYER_SCALE_BASE_ADDR = MACC_COEFF_BASE_ADDR + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    conv_weight_loader_if.slave        s,
    output logic [31:0]                weight_wr_data,
    output logic [31:0]                weight_wr_addr,
    output logic                       weight_wr_en,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int NK = KERNEL_0 * KERNEL_1 * IN_CHANNEL * OUT_CHANNEL;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KERN  = 3'd1,
        ST_BIAS  = 3'd2,
        ST_MACC  = 3'd3,
        ST_SCALE = 3'd4,
        ST_CKSUM = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t      state;
    logic [31:0] idx;

    logic        xfer;
    logic        last_word;
    logic [31:0] sec_base;
    logic [31:0] sec_last;
    state_t      sec_next;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [31:0] sum;
    logic        cksum_bad;
    logic        err_q;
`endif

    // s_ready is a pure decode of the state register, so it is glitch-free
    // and already valid for the whole cycle in which the source samples it.
    assign s.s_ready = (state == ST_KERN)  || (state == ST_BIAS) ||
                       (state == ST_MACC)  || (state == ST_SCALE) ||
                       (state == ST_CKSUM);

    assign xfer = s.s_valid & s.s_ready;

    // Section geometry for the current payload state: base address, index of
    // the last word, and the state that follows the section's last word.
    always_comb begin
        sec_base = 32'd0;
        sec_last = 32'd0;
        sec_next = ST_IDLE;
        case (state)
            ST_KERN: begin
                sec_base = 32'(KERNEL_BASE_ADDR);
                sec_last = 32'(NK - 1);
                sec_next = ST_BIAS;
            end
            ST_BIAS: begin
                sec_base = 32'(BIAS_BASE_ADDR);
                sec_last = 32'(OUT_CHANNEL - 1);
                sec_next = ST_MACC;
            end
            ST_MACC: begin
                sec_base = 32'(MACC_COEFF_BASE_ADDR);
                sec_last = 32'd0;
                sec_next = ST_SCALE;
            end
            ST_SCALE: begin
                sec_base = 32'(LAYER_SCALE_BASE_ADDR);
                sec_last = 32'd0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                sec_next = ST_CKSUM;
`else
                sec_next = ST_DONE;
`endif
            end
            default: begin
                sec_base = 32'd0;
                sec_last = 32'd0;
                sec_next = ST_IDLE;
            end
        endcase
    end

    // Last-word detection uses the index of the word being transferred now,
    // so the next section starts on the very next transfer without a bubble.
    assign last_word = (idx == sec_last);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Main sequencer: state, section index, registered write port, busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            idx            <= 32'd0;
            weight_wr_data <= 32'd0;
            weight_wr_addr <= 32'd0;
            weight_wr_en   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            sum            <= 32'd0;
            cksum_bad      <= 1'b0;
            err_q          <= 1'b0;
`endif
        end else begin
            weight_wr_en <= 1'b0;
            done         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // busy is still high here only during the done cycle; a
                    // start seen then belongs to the finishing load and is dropped.
                    busy <= 1'b0;
                    idx  <= 32'd0;
                    if (start && !busy) begin
                        state <= ST_KERN;
                        busy  <= 1'b1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                        sum       <= 32'd0;
                        cksum_bad <= 1'b0;
                        err_q     <= 1'b0;
`endif
                    end
                end
                ST_KERN, ST_BIAS, ST_MACC, ST_SCALE: begin
                    if (xfer) begin
                        weight_wr_en   <= 1'b1;
                        weight_wr_data <= s.s_data;
                        weight_wr_addr <= sec_base + idx;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                        sum            <= sum + s.s_data;
`endif
                        if (last_word) begin
                            idx   <= 32'd0;
                            state <= sec_next;
                        end else begin
                            idx   <= idx + 32'd1;
                        end
                    end
                end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                ST_CKSUM: begin
                    // The trailer is only compared, never written to the conv.
                    if (xfer) begin
                        cksum_bad <= (s.s_data != sum);
                        state     <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                    err_q <= cksum_bad;
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
